// File: rtl/bits_n_word_pkg.sv
// ============================================================================
// Module  : bits_n_word_pkg
// Brief   : Shared defaults, output-register state type and counter sizing.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bits_n_word_pkg;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_RATIO = 4;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } out_state_t;

  // Lane counter width; a 2-lane packer still needs one bit.
  function automatic int cnt_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bits_n_word_outreg.sv
// ============================================================================
// Module  : bits_n_word_outreg
// Brief   : Output word register with load/hold/drain and delivered-word count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bits_n_word_outreg
  import bits_n_word_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter int RATIO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [OUT_W-1:0] i_data,
  input  logic [RATIO-1:0] i_keep,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_data,
  output logic [RATIO-1:0] o_keep,
  output logic [15:0]      o_word_cnt
);

  out_state_t       r_state;
  out_state_t       w_state_nxt;
  logic [OUT_W-1:0] r_data;
  logic [RATIO-1:0] r_keep;
  logic [15:0]      r_word_cnt;
  logic             w_drain;

  assign w_drain = (r_state == S_FULL) && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A load in the same cycle as a drain keeps the register full with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (i_load) w_state_nxt = S_FULL;
      S_FULL: begin
        if (i_load) begin
          w_state_nxt = S_FULL;
        end else if (i_ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_keep     <= '0;
      r_word_cnt <= '0;
    end else begin
      if (i_load) begin
        r_data <= i_data;
        r_keep <= i_keep;
      end
      if (w_drain) begin
        r_word_cnt <= r_word_cnt + 16'd1;
      end
    end
  end

  assign o_valid    = (r_state == S_FULL);
  assign o_data     = r_data;
  assign o_keep     = r_keep;
  assign o_word_cnt = r_word_cnt;

endmodule

`default_nettype wire

// File: rtl/bits_n_word_packer.sv
// ============================================================================
// Module  : bits_n_word_packer
// Brief   : Packs RATIO narrow lanes into one wide word with optional idle flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bits_n_word_packer
  import bits_n_word_pkg::*;
#(
  parameter int IN_W          = DEF_IN_W,
  parameter int RATIO         = DEF_RATIO,
  parameter int MSB_FIRST     = 1,
  parameter int FLUSH_ON_IDLE = 1
) (
  input  logic                  clk_4f,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [IN_W-1:0]       Data_in,
  output logic                  ready_in,
  input  logic                  ready_out,
  output logic                  valid_out,
  output logic [IN_W*RATIO-1:0] Data_out,
  output logic [RATIO-1:0]      keep_out,
  output logic [15:0]           word_cnt
);

  localparam int              OUT_W  = IN_W * RATIO;
  localparam int              CW     = cnt_width(RATIO);
  localparam logic [CW-1:0]   C_LAST = CW'(RATIO - 1);

  logic [CW-1:0]    r_cnt;
  logic [OUT_W-1:0] r_acc;
  logic [RATIO-1:0] r_keep;

  logic             w_valid_out;
  logic             w_ready_in;
  logic             w_accept;
  logic             w_full_close;
  logic             w_part_close;
  logic             w_load;
  logic [CW-1:0]    w_slot;
  logic [OUT_W-1:0] w_acc_nxt;
  logic [RATIO-1:0] w_keep_nxt;

  assign w_ready_in   = !(w_valid_out && !ready_out);
  assign w_accept     = valid_in && w_ready_in;
  assign w_full_close = w_accept && (r_cnt == C_LAST);
  assign w_part_close = (FLUSH_ON_IDLE != 0) && !valid_in && (r_cnt != '0) && w_ready_in;
  assign w_load       = w_full_close || w_part_close;
  assign w_slot       = (MSB_FIRST != 0) ? (C_LAST - r_cnt) : r_cnt;

  // Accumulator with the incoming lane merged; this is also the word loaded on close.
  always_comb begin
    w_acc_nxt  = r_acc;
    w_keep_nxt = r_keep;
    if (w_accept) begin
      for (int i = 0; i < RATIO; i++) begin
        if (w_slot == CW'(i)) begin
          w_acc_nxt[i*IN_W +: IN_W] = Data_in;
          w_keep_nxt[i]             = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_keep <= '0;
    end else if (w_load) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_keep <= '0;
    end else if (w_accept) begin
      r_cnt  <= r_cnt + CW'(1);
      r_acc  <= w_acc_nxt;
      r_keep <= w_keep_nxt;
    end
  end

  bits_n_word_outreg #(
    .OUT_W (OUT_W),
    .RATIO (RATIO)
  ) u_outreg (
    .clk        (clk_4f),
    .rst_n      (reset),
    .i_load     (w_load),
    .i_data     (w_acc_nxt),
    .i_keep     (w_keep_nxt),
    .i_ready    (ready_out),
    .o_valid    (w_valid_out),
    .o_data     (Data_out),
    .o_keep     (keep_out),
    .o_word_cnt (word_cnt)
  );

  assign valid_out = w_valid_out;
  assign ready_in  = w_ready_in;

endmodule

`default_nettype wire

// File: tb/tb_bits_n_word_packer.sv
// ============================================================================
// Module  : tb_bits_n_word_packer
// Brief   : Three packer configurations driven in parallel against a lane-list model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bits_n_word_packer;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  din;

  logic        rdy  [N];
  logic        vo   [N];
  logic [31:0] dout [N];
  logic [3:0]  kout [N];
  logic [15:0] wc   [N];

  always #5 clk = ~clk;

  // inst0: defaults, inst1: LSB-first, inst2: hold partial words on idle
  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      bits_n_word_packer #(
        .IN_W          (8),
        .RATIO         (4),
        .MSB_FIRST     ((g == 1) ? 0 : 1),
        .FLUSH_ON_IDLE ((g == 2) ? 0 : 1)
      ) u_dut (
        .clk_4f    (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .Data_in   (din),
        .ready_in  (rdy[g]),
        .ready_out (ready_out),
        .valid_out (vo[g]),
        .Data_out  (dout[g]),
        .keep_out  (kout[g]),
        .word_cnt  (wc[g])
      );
    end
  endgenerate

  bit          msb_cfg [N] = '{1'b1, 1'b0, 1'b1};
  bit          fl_cfg  [N] = '{1'b1, 1'b1, 1'b0};
  logic [7:0]  m_lanes [N][4];
  int          m_n     [N];
  logic        m_ov    [N];
  logic [31:0] m_od    [N];
  logic [3:0]  m_ok    [N];
  logic [15:0] m_wc    [N];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %h, want %h", name, inst, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_n[i] = 0; m_ov[i] = 1'b0; m_od[i] = '0; m_ok[i] = '0; m_wc[i] = '0;
    end
  endtask

  // One clock of the packer described as a list of collected lanes per word.
  task automatic model_update();
    logic rin, load;
    logic [31:0] d;
    logic [3:0]  k;
    int slot;
    for (int i = 0; i < N; i++) begin
      if (!reset) begin
        m_n[i] = 0; m_ov[i] = 1'b0; m_od[i] = '0; m_ok[i] = '0; m_wc[i] = '0;
      end else begin
        rin  = !(m_ov[i] && !ready_out);
        load = 1'b0;
        if (m_ov[i] && ready_out) m_wc[i] = m_wc[i] + 16'd1;
        if (valid_in && rin) begin
          m_lanes[i][m_n[i]] = din;
          m_n[i]++;
          if (m_n[i] == 4) load = 1'b1;
        end else if (fl_cfg[i] && !valid_in && m_n[i] > 0 && rin) begin
          load = 1'b1;
        end
        if (load) begin
          d = '0; k = '0;
          for (int j = 0; j < m_n[i]; j++) begin
            slot = msb_cfg[i] ? 3 - j : j;
            d[slot*8 +: 8] = m_lanes[i][j];
            k[slot] = 1'b1;
          end
          m_od[i] = d; m_ok[i] = k; m_ov[i] = 1'b1; m_n[i] = 0;
        end else if (m_ov[i] && ready_out) begin
          m_ov[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic model_cmp();
    for (int i = 0; i < N; i++) begin
      chk("ready_in", i, 32'(rdy[i]), 32'(!(m_ov[i] && !ready_out)));
      chk("valid_out", i, 32'(vo[i]), 32'(m_ov[i]));
      chk("word_cnt", i, 32'(wc[i]), 32'(m_wc[i]));
      if (m_ov[i] || !reset) begin
        chk("Data_out", i, dout[i], m_od[i]);
        chk("keep_out", i, 32'(kout[i]), 32'(m_ok[i]));
      end
    end
  endtask

  // Called at negedge+1: compare, take the rising edge, land at the next negedge+1.
  task automatic step();
    #1 model_cmp();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic lane(input logic [7:0] b);
    valid_in = 1'b1; din = b; step();
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    reset = 1'b0;
    model_clear();
    #1 model_cmp();
    chk("rst_valid", 0, 32'(vo[0]), 32'd0);
    chk("rst_data", 0, dout[0], 32'd0);
    chk("rst_cnt", 0, 32'(wc[0]), 32'd0);
    step(); step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; din = '0; ready_out = 1'b1;
    model_clear();
    @(negedge clk); #1;
    chk("init_valid", 0, 32'(vo[0]), 32'd0);
    chk("init_keep", 0, 32'(kout[0]), 32'd0);
    step();
    reset = 1'b1;

    // back-to-back full words
    lane(8'hFF); lane(8'hAA); lane(8'hFF); lane(8'hBB);
    chk("w1_data", 0, dout[0], 32'hFFAAFFBB);
    chk("w1_keep", 0, 32'(kout[0]), 32'hF);
    chk("w1_lsb", 1, dout[1], 32'hBBFFAAFF);
    lane(8'hDD); lane(8'hCC); lane(8'hDD); lane(8'hEE);
    chk("w2_data", 0, dout[0], 32'hDDCCDDEE);
    idle(1);
    chk("w2_cnt", 0, 32'(wc[0]), 32'd2);

    // partial word closed by an idle cycle
    lane(8'h01); lane(8'h0F); lane(8'h0A);
    idle(1);
    chk("part_valid", 0, 32'(vo[0]), 32'd1);
    chk("part_data", 0, dout[0], 32'h010F0A00);
    chk("part_keep", 0, 32'(kout[0]), 32'hE);
    chk("hold_valid", 2, 32'(vo[2]), 32'd0);
    idle(2);
    do_reset();

    // LSB-first ordering
    lane(8'h01); lane(8'h02); lane(8'h03); lane(8'h04);
    chk("lsb_data", 1, dout[1], 32'h04030201);
    chk("msb_data", 0, dout[0], 32'h01020304);
    idle(1);

    // partial word held across a gap when idle flush is off
    lane(8'h11); lane(8'h22);
    idle(5);
    lane(8'h33); lane(8'h44);
    chk("held_data", 2, dout[2], 32'h11223344);
    chk("held_keep", 2, 32'(kout[2]), 32'hF);
    idle(2);

    // backpressure: held word stays put, offered lane waits
    ready_out = 1'b0;
    lane(8'h51); lane(8'h52); lane(8'h53); lane(8'h54);
    for (int c = 0; c < 3; c++) begin
      lane(8'h61);
      chk("bp_ready", 0, 32'(rdy[0]), 32'd0);
      chk("bp_data", 0, dout[0], 32'h51525354);
    end
    ready_out = 1'b1;
    lane(8'h61); lane(8'h62); lane(8'h63); lane(8'h64);
    chk("bp_next", 0, dout[0], 32'h61626364);
    idle(1);

    // reset mid-word discards the partial lanes
    lane(8'hB1); lane(8'hB2);
    do_reset();
    lane(8'hA1); lane(8'hA2); lane(8'hA3); lane(8'hA4);
    chk("post_rst", 0, dout[0], 32'hA1A2A3A4);
    idle(3);
    chk("post_cnt", 0, 32'(wc[0]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bits_n_word_packer.md
BITS_N_WORD_PACKER -- requirements
Module: bits_n_word_packer

Interface
REQ-001 SHALL have parameter IN_W, default 8, meaning input lane width in bits.
REQ-002 SHALL have parameter RATIO, default 4, meaning input lanes per output word (OUT_W = IN_W*RATIO); legal range 2..16.
REQ-003 SHALL have parameter MSB_FIRST, default 1, meaning first accepted lane lands in the most-significant slot; 0 = least-significant slot.
REQ-004 SHALL have parameter FLUSH_ON_IDLE, default 1, meaning a valid_in gap closes a partial word; 0 = partial word is held until filled.
REQ-005 SHALL have clk_4f, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have reset, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have valid_in, input, 1, Data_in qualifier.
REQ-008 SHALL have Data_in, input, IN_W, input lane.
REQ-009 SHALL have ready_in, output, 1, packer can accept a lane this cycle.
REQ-010 SHALL have ready_out, input, 1, downstream accepts Data_out this cycle.
REQ-011 SHALL have valid_out, output, 1, Data_out/keep_out hold a word.
REQ-012 SHALL have Data_out, output, OUT_W, packed word.
REQ-013 SHALL have keep_out, output, RATIO, per-slot lane-valid mask, bit i = slot i (slot 0 = LSB slot).
REQ-014 SHALL have word_cnt, output, 16, count of words delivered (valid_out && ready_out), wraps at 2^16.

Function
REQ-015 Lane accepted iff valid_in && ready_in; ready_in = !(valid_out && !ready_out) (combinational).
REQ-016 Lane counter cnt, 0..RATIO-1, indexes the slot being filled; increments per accepted lane, returns to 0 on word close.
REQ-017 Slot for lane k of a word: MSB_FIRST=1 -> slot RATIO-1-k; MSB_FIRST=0 -> slot k.
REQ-018 Full close: acceptance with cnt==RATIO-1 loads output register; valid_out=1 the next cycle (latency 1 cycle from last lane), keep_out all ones.
REQ-019 Partial close (FLUSH_ON_IDLE=1 only): cycle with valid_in=0, cnt>0, ready_in=1 loads output register with filled slots, unfilled slots zero, keep_out marking filled slots only; cnt->0.
REQ-020 FLUSH_ON_IDLE=0: valid_in gaps hold cnt and accumulator unchanged indefinitely.
REQ-021 Output register holds Data_out/keep_out stable while valid_out && !ready_out; clears valid_out on ready_out unless a new word loads the same cycle.
REQ-022 Simultaneous drain and close: new word loads and valid_out stays 1 with no bubble.
REQ-023 Accumulator slots are cleared to zero on each word close so partial words never carry stale lanes.
REQ-024 word_cnt increments by 1 per handshake, including partial words.

Reset
REQ-025 reset low SHALL immediately force valid_out=0, Data_out=0, keep_out=0, word_cnt=0, cnt=0, accumulator=0, regardless of clock.
REQ-026 Reset mid-word SHALL discard the partial word; no flush is emitted on deassertion.
REQ-027 First lane acceptance possible on the first rising edge after reset goes high.

Structure
REQ-028 Package bits_n_word_pkg SHALL hold default parameter constants (IN_W, RATIO) and the clog2-based counter width function.
REQ-029 One sub-module bits_n_word_outreg (output register with hold/load/drain) is natural; packing logic stays in the top.

Verification
REQ-030 Defaults, ready_out=1, lanes FF,AA,FF,BB then DD,CC,DD,EE back-to-back -> Data_out=FFAAFFBB then DDCCDDEE, each one cycle after its 4th lane, keep_out=F, word_cnt=2.
REQ-031 Lanes 01,0F,0A then valid_in=0 -> Data_out=010F0A00, keep_out=E, valid_out one cycle after the idle cycle.
REQ-032 MSB_FIRST=0, lanes 01,02,03,04 -> Data_out=04030201.
REQ-033 FLUSH_ON_IDLE=0, lanes 11,22, 5 idle cycles, 33,44 -> single word 11223344, no partial word emitted.
REQ-034 ready_out=0 with a word held, 4 more lanes offered -> ready_in=0, Data_out stable; ready_out=1 -> held word drains, next word follows with no lane lost.
REQ-035 reset low after 2 lanes, then lanes A1,A2,A3,A4 -> only word A1A2A3A4 emitted, all outputs 0 during reset.
